// File: rtl/quad_upconverter.sv
// Quadrature upconverter: FIFO-fed zero-order hold of baseband I/Q, mixed with the NCO carrier
// into a rounded, saturated real IF stream with a fixed 3-cycle mixer latency.
module quad_upconverter #(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned NCO_W      = 18,
  parameter int unsigned OUT_W      = 18,
  parameter int unsigned INTERP     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          ipClk,
  input  logic                          ipReset,
  input  logic                          ipEnable,
  input  logic [DATA_W-1:0]             ipI,
  input  logic [DATA_W-1:0]             ipQ,
  input  logic                          ipValid,
  output logic                          opReady,
  input  logic [NCO_W-1:0]              ipNcoI,
  input  logic [NCO_W-1:0]              ipNcoQ,
  output logic [OUT_W-1:0]              opData,
  output logic                          opValid,
  output logic                          opUnderflow,
  input  logic                          ipClearFlags,
  output logic [$clog2(FIFO_DEPTH):0]   opFifoLevel
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned CntW  = $clog2(INTERP);
  localparam int unsigned ProdW = DATA_W + NCO_W;
  localparam int unsigned DiffW = ProdW + 1;
  localparam int unsigned Shift = ProdW - 1 - OUT_W;

  localparam logic signed [DiffW-1:0] RoundC = {{(DiffW-1){1'b0}}, 1'b1} << (Shift - 1);
  localparam logic [OUT_W-1:0] SatMax = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SatMin = {1'b1, {(OUT_W-1){1'b0}}};

  // run_q keeps opReady low until the first clock after reset release
  logic                     run_q;
  logic [LvlW-1:0]          level_q, level_d;
  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic signed [DATA_W-1:0] mem_i_q [FIFO_DEPTH];
  logic signed [DATA_W-1:0] mem_q_q [FIFO_DEPTH];
  logic [CntW-1:0]          count_q, count_d;
  logic signed [DATA_W-1:0] hold_i_q, hold_q_q;
  logic                     underflow_q;
  logic                     push, pop, load_slot, fifo_full, fifo_empty;

  logic signed [ProdW-1:0]  prod_i, prod_q, p_i_q, p_q_q;
  logic signed [DiffW-1:0]  diff_d, diff_q, rounded, shifted;
  logic [OUT_W-1:0]         sat_val, data_q;
  logic                     v1_q, v2_q, v3_q;

  assign fifo_full   = (level_q == LvlW'(FIFO_DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign opReady     = run_q & ~fifo_full;
  assign push        = ipValid & opReady;
  assign load_slot   = ipEnable & (count_q == '0);
  assign pop         = load_slot & ~fifo_empty;
  assign opFifoLevel = level_q;
  assign opUnderflow = underflow_q;
  assign opData      = data_q;
  assign opValid     = v3_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (ipEnable) begin
      count_d = (count_q == CntW'(INTERP - 1)) ? '0 : count_q + CntW'(1);
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      run_q    <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_i_q[k] <= '0;
        mem_q_q[k] <= '0;
      end
    end else begin
      run_q   <= 1'b1;
      level_q <= level_d;
      if (push) begin
        mem_i_q[wr_ptr_q] <= ipI;
        mem_q_q[wr_ptr_q] <= ipQ;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // An empty load slot holds zero; setting underflow wins over a same-cycle clear
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      count_q     <= '0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (load_slot) begin
        hold_i_q <= fifo_empty ? '0 : mem_i_q[rd_ptr_q];
        hold_q_q <= fifo_empty ? '0 : mem_q_q[rd_ptr_q];
      end
      if (load_slot && fifo_empty) begin
        underflow_q <= 1'b1;
      end else if (ipClearFlags) begin
        underflow_q <= 1'b0;
      end
    end
  end

  always_comb begin
    prod_i  = ProdW'(hold_i_q) * ProdW'($signed(ipNcoI));
    prod_q  = ProdW'(hold_q_q) * ProdW'($signed(ipNcoQ));
    diff_d  = DiffW'(p_i_q) - DiffW'(p_q_q);
    rounded = diff_q + RoundC;
    shifted = rounded >>> Shift;
    sat_val = shifted[OUT_W-1:0];
    // Bits above the output sign must all match the sign, otherwise clip
    if ((shifted[DiffW-1:OUT_W-1] != '0) && (shifted[DiffW-1:OUT_W-1] != '1)) begin
      sat_val = shifted[DiffW-1] ? SatMin : SatMax;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      p_i_q  <= '0;
      p_q_q  <= '0;
      diff_q <= '0;
      data_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
    end else begin
      p_i_q  <= prod_i;
      p_q_q  <= prod_q;
      diff_q <= diff_d;
      v1_q   <= ipEnable;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      if (v2_q) begin
        data_q <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_quad_upconverter.sv
// Randomised scoreboard bench for quad_upconverter: a queue-based hold/mix model predicts each
// output sample and its arrival cycle; a monitor pops and compares whenever opValid is seen.
module tb_quad_upconverter;

  localparam int DW = 18;
  localparam int NW = 18;
  localparam int OW = 18;
  localparam int INTERP = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, vld, clr;
  logic [DW-1:0] din_i, din_q;
  logic [NW-1:0] nco_i, nco_q;
  logic          ready, out_valid, underflow;
  logic [OW-1:0] out_data;
  logic [2:0]    level;

  always #5 clk = ~clk;

  quad_upconverter #(
    .DATA_W(DW), .NCO_W(NW), .OUT_W(OW), .INTERP(INTERP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .ipClk(clk), .ipReset(rst_n), .ipEnable(en), .ipI(din_i), .ipQ(din_q), .ipValid(vld),
    .opReady(ready), .ipNcoI(nco_i), .ipNcoQ(nco_q), .opData(out_data), .opValid(out_valid),
    .opUnderflow(underflow), .ipClearFlags(clr), .opFifoLevel(level)
  );

  typedef struct {
    logic [OW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  typedef struct {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
  } smp_t;

  exp_t                 sb[$];
  smp_t                 mq[$];
  int                   n_cmp = 0;
  int                   n_err = 0;
  int unsigned          edge_cnt = 0;
  int                   m_cnt;
  logic signed [DW-1:0] m_hi, m_hq;
  bit                   m_uf, m_rdy;
  logic [OW-1:0]        last_data;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
    end
  endtask

  // y = sat(floor((I*Ni - Q*Nq) / 2^17 + 1/2)) in plain integer arithmetic
  function automatic logic [OW-1:0] ref_mix(input logic signed [DW-1:0] hi, hq,
                                            input logic signed [NW-1:0] ni, nq);
    longint a, b, c, d, num, y;
    longint den;
    a = hi; b = hq; c = ni; d = nq;
    den = longint'(1) << (DW + NW - 1 - OW);
    num = a * c - b * d + den / 2;
    y = num / den;
    if ((num % den != 0) && (num < 0)) y = y - 1;
    if (y > (longint'(1) << (OW - 1)) - 1) y = (longint'(1) << (OW - 1)) - 1;
    if (y < -(longint'(1) << (OW - 1))) y = -(longint'(1) << (OW - 1));
    return y[OW-1:0];
  endfunction

  // One clock: check state left by the previous edge, drive inputs, advance the model.
  task automatic step(input logic e, input logic v, input logic [DW-1:0] i, q,
                      input logic [NW-1:0] ni, nq, input logic c);
    bit   do_push, was_empty;
    smp_t s;
    chk("fifo_level", 32'(level), 32'(mq.size()));
    chk("ready", 32'(ready), 32'(m_rdy && mq.size() != DEPTH));
    chk("underflow", 32'(underflow), 32'(m_uf));
    en = e; vld = v; din_i = i; din_q = q; nco_i = ni; nco_q = nq; clr = c;
    do_push = v && m_rdy && (mq.size() != DEPTH);
    was_empty = (mq.size() == 0);
    if (e) sb.push_back('{data: ref_mix(m_hi, m_hq, ni, nq), cyc: edge_cnt + 3});
    if (e && m_cnt == 0) begin
      if (was_empty) begin
        m_hi = '0; m_hq = '0;
      end else begin
        s = mq.pop_front();
        m_hi = s.i; m_hq = s.q;
      end
    end
    if (e && m_cnt == 0 && was_empty) m_uf = 1'b1;
    else if (c) m_uf = 1'b0;
    if (e) m_cnt = (m_cnt + 1) % INTERP;
    if (do_push) begin
      s.i = i; s.q = q;
      mq.push_back(s);
    end
    m_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; en = 1'b0; vld = 1'b0; clr = 1'b0;
    #1;
    sb.delete(); mq.delete();
    m_cnt = 0; m_hi = '0; m_hq = '0; m_uf = 1'b0; m_rdy = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    repeat (cycles) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    #1;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst_n) begin
      last_data = '0;
    end else begin
      while (sb.size() != 0 && sb[0].cyc < edge_cnt) begin
        e = sb.pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_output: got nothing, expected 0x%0h at edge %0d", e.data, e.cyc);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_valid: got 0x%0h at edge %0d, expected no output",
                   out_data, edge_cnt);
        end else begin
          e = sb.pop_front();
          chk("mix_data", 32'(out_data), 32'(e.data));
          chk("latency", edge_cnt, e.cyc);
          last_data = out_data;
        end
      end else begin
        chk("data_hold", 32'(out_data), 32'(last_data));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] ramp;
    din_i = '0; din_q = '0; nco_i = '0; nco_q = '0;
    do_reset(3);

    // DC mix, then the FIFO runs dry
    step(1'b0, 1'b1, 18'h0FFFF, 18'h00000, 18'h1FFFF, 18'h00000, 1'b0);
    repeat (40) step(1'b1, 1'b0, '0, '0, 18'h1FFFF, 18'h00000, 1'b0);

    // Saturation towards both rails
    repeat (2) step(1'b0, 1'b1, 18'h20000, 18'h20000, 18'h20000, 18'h1FFFF, 1'b0);
    repeat (24) step(1'b1, 1'b0, '0, '0, 18'h20000, 18'h1FFFF, 1'b0);
    repeat (24) step(1'b1, 1'b0, '0, '0, 18'h1FFFF, 18'h20000, 1'b0);

    // Fill while disabled, push against backpressure, then drain
    repeat (6) step(1'b0, 1'b1, DW'($urandom), DW'($urandom), NW'($urandom), NW'($urandom), 1'b0);
    repeat (70) step(1'b1, 1'b0, '0, '0, NW'($urandom), NW'($urandom), 1'b0);

    // Clear in a load slot with an empty FIFO must lose to the new underflow
    while (m_cnt != 0) step(1'b1, 1'b0, '0, '0, NW'($urandom), NW'($urandom), 1'b0);
    step(1'b1, 1'b0, '0, '0, NW'($urandom), NW'($urandom), 1'b1);
    step(1'b1, 1'b0, '0, '0, NW'($urandom), NW'($urandom), 1'b1);
    repeat (3) step(1'b1, 1'b0, '0, '0, NW'($urandom), NW'($urandom), 1'b0);

    // Ramp stream against a random carrier, with a reset mid-stream
    ramp = 18'h30000;
    for (int n = 0; n < 4096; n++) begin
      if (n == 2000) do_reset(2);
      step($urandom_range(0, 15) != 0, $urandom_range(0, 11) == 0, ramp, DW'($urandom),
           NW'($urandom), NW'($urandom), $urandom_range(0, 63) == 0);
      if (vld && ready) ramp = ramp + 18'h00123;
    end

    repeat (6) step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
